// File: rtl/contador_pkg.sv
// Shared defaults and types for the up/down counter with prescaler.
package contador_pkg;

  localparam int CNT_W_DEF   = 4;
  localparam int DIV_MAX_DEF = 49_999_999;
  localparam int DIV_W_DEF   = 26;

  typedef enum logic [0:0] {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/freq_tick.sv
// Free-running prescaler: counts 0..DIV_MAX while enabled and flags the terminal cycle.
module freq_tick
  import contador_pkg::*;
#(
  parameter int DIV_MAX = DIV_MAX_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_MAX);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             at_last;

  // next prescaler value and the tick enable
  always_comb begin
    at_last = (div_q == LAST);
    tick    = en & at_last;
    div_d   = div_q;
    if (clr) begin
      div_d = {DIV_W{1'b0}};
    end else if (en) begin
      if (at_last) begin
        div_d = {DIV_W{1'b0}};
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = div_q;
    end
  end

  // prescaler register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= {DIV_W{1'b0}};
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/contador_updown_div.sv
// Up/down modulo counter advanced by a prescaler tick; optional square wave
// output enabled by defining CONTADOR_UPDOWN_DIV_SQW_EN.
module contador_updown_div
  import contador_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_MAX = DIV_MAX_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] mod_max,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             sqw
);

  logic             tick_ev;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tick_q;
  logic             tick_d;
  logic             wrap_q;
  logic             wrap_d;
  dir_e             dir;

  freq_tick #(
    .DIV_MAX (DIV_MAX),
    .DIV_W   (DIV_W)
  ) u_freq_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick_ev)
  );

  assign dir = up ? DIR_UP : DIR_DOWN;

  // next count and the tick/wrap flags; load overrides a coincident tick
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (tick_ev) begin
      tick_d = 1'b1;
      case (dir)
        DIR_UP: begin
          if (count_q < mod_max) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            count_d = {CNT_W{1'b0}};
            wrap_d  = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (count_q == {CNT_W{1'b0}}) begin
            count_d = mod_max;
            wrap_d  = 1'b1;
          end else if (count_q > mod_max) begin
            // out-of-range value snaps into range without flagging a wrap
            count_d = mod_max;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // counter and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

`ifdef CONTADOR_UPDOWN_DIV_SQW_EN
  logic sqw_q;
  logic sqw_d;

  // toggles on every prescaler tick, independent of load
  always_comb begin
    if (tick_ev) begin
      sqw_d = ~sqw_q;
    end else begin
      sqw_d = sqw_q;
    end
  end

  // square wave register
  always_ff @(posedge clk) begin
    if (rst) begin
      sqw_q <= 1'b0;
    end else begin
      sqw_q <= sqw_d;
    end
  end

  assign sqw = sqw_q;
`else
  assign sqw = 1'b0;
`endif

endmodule

// File: tb/tb_contador_updown_div.sv
// Directed bench for contador_updown_div with an arithmetic reference model.
module tb_contador_updown_div;

  localparam int CNT_W   = 4;
  localparam int DIV_MAX = 3;
  localparam int DIV_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             up = 1'b1;
  logic             load = 1'b0;
  logic [CNT_W-1:0] load_val = 4'd0;
  logic [CNT_W-1:0] mod_max = 4'd9;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             wrap;
  logic             sqw;

  int checks = 0;
  int errors = 0;

  contador_updown_div #(
    .CNT_W   (CNT_W),
    .DIV_MAX (DIV_MAX),
    .DIV_W   (DIV_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .mod_max  (mod_max),
    .count    (count),
    .tick     (tick),
    .wrap     (wrap),
    .sqw      (sqw)
  );

  always #5 clk = ~clk;

  // reference model: phase counter plus the counting rules in plain integers
  int m_pre = 0;
  int m_cnt = 0;
  bit m_tick = 1'b0;
  bit m_wrap = 1'b0;
  bit m_sqw = 1'b0;
  bit m_valid = 1'b0;

  function automatic int rule_next(int c, int mm, bit dir_up);
    if (dir_up) return (c < mm) ? c + 1 : 0;
    if (c == 0) return mm;
    if (c > mm) return mm;
    return c - 1;
  endfunction

  function automatic bit rule_wrap(int c, int mm, bit dir_up);
    if (dir_up) return c >= mm;
    return c == 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pre <= 0; m_cnt <= 0; m_tick <= 1'b0; m_wrap <= 1'b0; m_sqw <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      if (load) begin
        m_cnt <= int'(load_val); m_tick <= 1'b0; m_wrap <= 1'b0; m_pre <= 0;
      end else if (en && m_pre == DIV_MAX) begin
        m_cnt  <= rule_next(m_cnt, int'(mod_max), up);
        m_wrap <= rule_wrap(m_cnt, int'(mod_max), up);
        m_tick <= 1'b1;
        m_pre  <= 0;
      end else begin
        m_tick <= 1'b0; m_wrap <= 1'b0;
        if (en) m_pre <= (m_pre + 1) % (DIV_MAX + 1);
      end
`ifdef CONTADOR_UPDOWN_DIV_SQW_EN
      if (en && m_pre == DIV_MAX) m_sqw <= ~m_sqw;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count", 32'(count), 32'(m_cnt));
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
      chk("model_sqw", 32'(sqw), 32'(m_sqw));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [CNT_W-1:0] vec_mod [6];
  logic             vec_up  [6];

  initial begin
    vec_mod[0] = 4'd5;  vec_up[0] = 1'b1;
    vec_mod[1] = 4'd2;  vec_up[1] = 1'b0;
    vec_mod[2] = 4'd0;  vec_up[2] = 1'b1;
    vec_mod[3] = 4'd15; vec_up[3] = 1'b1;
    vec_mod[4] = 4'd0;  vec_up[4] = 1'b0;
    vec_mod[5] = 4'd7;  vec_up[5] = 1'b0;

    step(2);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    chk("reset_sqw", 32'(sqw), 32'd0);

    // free run up, mod 9: tick every 4th edge, wrap at the 10th tick
    rst = 1'b0; en = 1'b1; up = 1'b1; mod_max = 4'd9;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      chk("run_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("run_count", 32'(count), 32'((k / 4) % 10));
      chk("run_wrap", 32'(wrap), (k == 40) ? 32'd1 : 32'd0);
`ifdef CONTADOR_UPDOWN_DIV_SQW_EN
      chk("run_sqw", 32'(sqw), 32'((k / 4) % 2));
`else
      chk("run_sqw", 32'(sqw), 32'd0);
`endif
    end

    // load 0 then count down: 9 with wrap, then 8 without
    load = 1'b1; load_val = 4'd0; up = 1'b0;
    step(1);
    chk("ld0_count", 32'(count), 32'd0);
    chk("ld0_tick", 32'(tick), 32'd0);
    load = 1'b0;
    step(4);
    chk("dn_first_count", 32'(count), 32'd9);
    chk("dn_first_wrap", 32'(wrap), 32'd1);
    step(4);
    chk("dn_second_count", 32'(count), 32'd8);
    chk("dn_second_wrap", 32'(wrap), 32'd0);
    chk("dn_second_tick", 32'(tick), 32'd1);

    // load coinciding with the prescaler terminal cycle
    step(3);
    load = 1'b1; load_val = 4'd5; up = 1'b1;
    step(1);
    chk("ld5_count", 32'(count), 32'd5);
    chk("ld5_tick", 32'(tick), 32'd0);
    chk("ld5_wrap", 32'(wrap), 32'd0);
    load = 1'b0;
    step(3);
    chk("ld5_no_early_tick", 32'(tick), 32'd0);
    step(1);
    chk("ld5_next_count", 32'(count), 32'd6);
    chk("ld5_next_tick", 32'(tick), 32'd1);

    // pause mid-period
    step(2);
    en = 1'b0;
    step(7);
    chk("pause_count", 32'(count), 32'd6);
    chk("pause_tick", 32'(tick), 32'd0);
    en = 1'b1;
    step(1);
    chk("resume_no_tick", 32'(tick), 32'd0);
    step(1);
    chk("resume_tick", 32'(tick), 32'd1);
    chk("resume_count", 32'(count), 32'd7);

    // out-of-range load
    load = 1'b1; load_val = 4'd12; up = 1'b1;
    step(1);
    chk("oor_load_count", 32'(count), 32'd12);
    load = 1'b0;
    step(4);
    chk("oor_up_count", 32'(count), 32'd0);
    chk("oor_up_wrap", 32'(wrap), 32'd1);
    load = 1'b1; up = 1'b0;
    step(1);
    load = 1'b0;
    step(4);
    chk("oor_dn_count", 32'(count), 32'd9);
    chk("oor_dn_wrap", 32'(wrap), 32'd0);
    chk("oor_dn_tick", 32'(tick), 32'd1);

    // reset mid-period wins over load and discards prescaler progress
    up = 1'b1;
    step(2);
    rst = 1'b1; load = 1'b1; load_val = 4'd7;
    step(1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_sqw", 32'(sqw), 32'd0);
    rst = 1'b0; load = 1'b0;
    step(3);
    chk("rst_no_early_tick", 32'(tick), 32'd0);
    step(1);
    chk("rst_first_tick", 32'(tick), 32'd1);
    chk("rst_first_count", 32'(count), 32'd1);

    // mid-run direction and range changes, checked by the model
    for (int v = 0; v < 6; v++) begin
      step(2);
      up = vec_up[v]; mod_max = vec_mod[v];
      step(9);
    end

    step(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
